// File: rtl/reg_access_pkg.sv
// Shared types and register-block geometry for the register-access arbiter.
package reg_access_pkg;

  localparam int unsigned REG_AW = 3;
  localparam int unsigned REG_DW = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_pick #(
  parameter  int unsigned NREQ = 2,
  localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   index,
  output logic            any
);

  always_comb begin
    int unsigned j;
    j     = 0;
    grant = '0;
    index = '0;
    any   = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = (32'(ptr) + k) % NREQ;
      if (!any && req[PW'(j)]) begin
        any   = 1'b1;
        index = PW'(j);
      end
    end
    if (any) grant = NREQ'(1) << index;
  end

endmodule

// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter sharing the register-block access port between NREQ requesters.
// One transaction at a time: IDLE -> ISSUE (strobe) -> [WAIT] -> RESP (ack).
module reg_access_arbiter
  import reg_access_pkg::*;
#(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned AW     = REG_AW,
  parameter int unsigned DW     = REG_DW,
  parameter int unsigned RD_LAT = 0
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NREQ-1:0]    REQ,
  input  logic [NREQ-1:0]    REQ_WE,
  input  logic [NREQ*AW-1:0] REQ_ADDR,
  input  logic [NREQ*DW-1:0] REQ_WDATA,
  output logic [NREQ-1:0]    GNT,
  output logic [NREQ-1:0]    ACK,
  output logic [DW-1:0]      RSP_RDATA,
  output logic               WRITE,
  output logic               READ,
  output logic [AW-1:0]      ADDR,
  output logic [DW-1:0]      WRITE_DATA,
  input  logic [DW-1:0]      READ_DATA
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = 3;

  arb_state_e      state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   sel_q, sel_d;
  logic            we_q, we_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_d, ack_d;
  logic            write_d, read_d;
  logic [AW-1:0]   addr_d;
  logic [DW-1:0]   wdata_d, rdata_d;

  logic [NREQ-1:0] pick_grant;
  logic [PW-1:0]   pick_idx;
  logic            pick_any;
  logic [NREQ-1:0] sel_oh;
  logic [PW-1:0]   ptr_nxt;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (REQ),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .index (pick_idx),
    .any   (pick_any)
  );

  assign sel_oh  = NREQ'(1) << sel_q;
  assign ptr_nxt = (sel_q == PW'(NREQ - 1)) ? '0 : sel_q + PW'(1);

  // Next state and next values of every registered output.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    ack_d   = '0;
    write_d = 1'b0;
    read_d  = 1'b0;
    addr_d  = ADDR;
    wdata_d = WRITE_DATA;
    rdata_d = '0;
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          sel_d   = pick_idx;
          we_d    = REQ_WE[pick_idx];
          addr_d  = REQ_ADDR[pick_idx*AW +: AW];
          wdata_d = REQ_WDATA[pick_idx*DW +: DW];
          gnt_d   = pick_grant;
          write_d = REQ_WE[pick_idx];
          read_d  = !REQ_WE[pick_idx];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          ack_d   = sel_oh;
          state_d = S_RESP;
        end else if (RD_LAT == 0) begin
          rdata_d = READ_DATA;
          ack_d   = sel_oh;
          state_d = S_RESP;
        end else begin
          cnt_d   = CW'(RD_LAT);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          rdata_d = READ_DATA;
          ack_d   = sel_oh;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        ptr_d   = ptr_nxt;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      GNT        <= '0;
      ACK        <= '0;
      WRITE      <= 1'b0;
      READ       <= 1'b0;
      ADDR       <= '0;
      WRITE_DATA <= '0;
      RSP_RDATA  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      GNT        <= gnt_d;
      ACK        <= ack_d;
      WRITE      <= write_d;
      READ       <= read_d;
      ADDR       <= addr_d;
      WRITE_DATA <= wdata_d;
      RSP_RDATA  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench for reg_access_arbiter; two instances (read latency 2 and 3) share stimulus.
module tb_reg_access_arbiter;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [1:0] REQ;
  logic [1:0] REQ_WE;
  logic [5:0] REQ_ADDR;
  logic [3:0] REQ_WDATA;
  logic [1:0] READ_DATA;

  logic [1:0] GNT_a, ACK_a, RSP_a, WD_a;
  logic       WRITE_a, READ_a;
  logic [2:0] ADDR_a;
  logic [1:0] GNT_b, ACK_b, RSP_b, WD_b;
  logic       WRITE_b, READ_b;
  logic [2:0] ADDR_b;

  int n_checks;
  int n_fail;

  always #5 CLK = ~CLK;

  reg_access_arbiter #(.NREQ(2), .AW(3), .DW(2), .RD_LAT(2)) u_dut_a (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .GNT(GNT_a), .ACK(ACK_a), .RSP_RDATA(RSP_a),
    .WRITE(WRITE_a), .READ(READ_a), .ADDR(ADDR_a), .WRITE_DATA(WD_a),
    .READ_DATA(READ_DATA)
  );

  reg_access_arbiter #(.NREQ(2), .AW(3), .DW(2), .RD_LAT(3)) u_dut_b (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .GNT(GNT_b), .ACK(ACK_b), .RSP_RDATA(RSP_b),
    .WRITE(WRITE_b), .READ(READ_b), .ADDR(ADDR_b), .WRITE_DATA(WD_b),
    .READ_DATA(READ_DATA)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int r;
    n_checks  = 0;
    n_fail    = 0;
    RST_N     = 1'b0;
    REQ       = 2'b11;
    REQ_WE    = 2'b11;
    REQ_ADDR  = {3'd6, 3'd1};
    REQ_WDATA = {2'b11, 2'b01};
    READ_DATA = 2'b01;

    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_outs_a", 32'({GNT_a, ACK_a, WRITE_a, READ_a, ADDR_a, WD_a, RSP_a}), 0);
    end
    RST_N = 1'b1;

    // Both requesting writes: strict rotation 0,1,0,1, one grant every 3 cycles.
    for (int n = 0; n < 4; n++) begin
      r = n % 2;
      tick();
      check("cont_gnt", 32'(GNT_a), 1 << r);
      check("cont_strobe", 32'({WRITE_a, READ_a}), 2);
      check("cont_addr", 32'(ADDR_a), (r == 1) ? 6 : 1);
      check("cont_wdata", 32'(WD_a), (r == 1) ? 3 : 1);
      if (n == 3) REQ = 2'b00;
      tick();
      check("cont_ack", 32'({GNT_a, ACK_a}), 1 << r);
      check("cont_resp_quiet", 32'({WRITE_a, READ_a, RSP_a}), 0);
      tick();
      check("cont_idle", 32'({GNT_a, ACK_a, WRITE_a, READ_a}), 0);
    end

    // Single write from requester 0.
    REQ       = 2'b01;
    REQ_WE    = 2'b01;
    REQ_ADDR  = {3'd7, 3'd0};
    REQ_WDATA = {2'b00, 2'b10};
    tick();
    check("wr_gnt", 32'(GNT_a), 1);
    check("wr_strobe", 32'({WRITE_a, READ_a}), 2);
    check("wr_addr", 32'(ADDR_a), 0);
    check("wr_wdata", 32'(WD_a), 2);
    tick();
    check("wr_ack", 32'(ACK_a), 1);
    check("wr_rsp_zero", 32'(RSP_a), 0);
    REQ = 2'b00;
    tick();
    check("wr_done", 32'({GNT_a, ACK_a}), 0);

    // Read from requester 1, latency 2; data valid only in the sampled cycle.
    REQ      = 2'b10;
    REQ_WE   = 2'b00;
    REQ_ADDR = {3'd0, 3'd5};
    tick();
    check("rd_gnt", 32'(GNT_a), 2);
    check("rd_strobe", 32'({WRITE_a, READ_a}), 1);
    check("rd_addr", 32'(ADDR_a), 0);
    tick();
    check("rd_wait1", 32'({ACK_a, READ_a, WRITE_a}), 0);
    check("rd_wait1_addr", 32'(ADDR_a), 0);
    tick();
    check("rd_wait2", 32'(ACK_a), 0);
    READ_DATA = 2'b10;
    tick();
    check("rd_ack", 32'(ACK_a), 2);
    check("rd_rdata", 32'(RSP_a), 2);
    READ_DATA = 2'b01;
    REQ       = 2'b00;
    tick();
    check("rd_done", 32'({ACK_a, RSP_a}), 0);

    // Fields latched at grant: later changes and REQ drop are ignored.
    REQ       = 2'b01;
    REQ_WE    = 2'b01;
    REQ_ADDR  = {3'd0, 3'd3};
    REQ_WDATA = {2'b00, 2'b01};
    tick();
    check("fc_gnt", 32'(GNT_a), 1);
    check("fc_addr", 32'(ADDR_a), 3);
    REQ_ADDR[2:0]  = 3'd5;
    REQ_WDATA[1:0] = 2'b11;
    REQ            = 2'b00;
    tick();
    check("fc_ack", 32'(ACK_a), 1);
    check("fc_addr_hold", 32'(ADDR_a), 3);
    check("fc_wdata_hold", 32'(WD_a), 1);
    tick();
    check("fc_idle", 32'({GNT_a, ACK_a}), 0);
    check("fc_addr_idle", 32'(ADDR_a), 3);

    // Mid-operation reset on the latency-3 instance, with the pointer advanced first.
    RST_N = 1'b0;
    REQ   = 2'b00;
    tick();
    RST_N     = 1'b1;
    REQ       = 2'b01;
    REQ_WE    = 2'b01;
    REQ_ADDR  = {3'd4, 3'd2};
    REQ_WDATA = {2'b00, 2'b10};
    tick();
    check("mop_wr_gnt_b", 32'(GNT_b), 1);
    check("mop_wr_strobe_b", 32'({WRITE_b, READ_b}), 2);
    tick();
    check("mop_wr_ack_b", 32'(ACK_b), 1);
    REQ = 2'b00;
    tick();
    REQ = 2'b10;
    tick();
    check("mop_rd_gnt_b", 32'(GNT_b), 2);
    check("mop_rd_strobe_b", 32'({WRITE_b, READ_b}), 1);
    check("mop_rd_addr_b", 32'(ADDR_b), 4);
    tick();
    check("mop_wait1_b", 32'({ACK_b, READ_b}), 0);
    tick();
    check("mop_wait2_b", 32'(ACK_b), 0);
    RST_N = 1'b0;
    tick();
    check("mop_rst_outs_b", 32'({GNT_b, ACK_b, WRITE_b, READ_b, ADDR_b, WD_b, RSP_b}), 0);
    RST_N  = 1'b1;
    REQ    = 2'b11;
    REQ_WE = 2'b11;
    tick();
    check("mop_regrant_b", 32'(GNT_b), 1);
    check("mop_no_stale_ack_b", 32'(ACK_b), 0);
    tick();
    check("mop_reack_b", 32'(ACK_b), 1);
    REQ = 2'b00;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
